instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- IF stage of the veriRISCV 5-stage core; sits directly upstream of the ID stage.
- Owns the fetch PC and drives a req/ready/rvalid instruction bus with at most one request outstanding.
- Delivers the IF/ID pipeline register (if2id_valid/pc/instruction).
- Supports stall from the HDU, PC redirect from branch/jump resolution, and a 1-entry skid buffer that absorbs a response arriving during a stall.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
if_stall  input  1  hold IF/ID register (HDU load_dependence)
redirect_valid  input  1  branch/jump taken; flush IF and refetch
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
ibus_read  output  1  fetch request
ibus_addr  output  32  fetch address, word aligned
ibus_ready  input  1  request accepted this cycle when ibus_read=1
ibus_rvalid  input  1  read data valid; one response per accepted request, earliest the cycle after accept
ibus_rdata  input  32  instruction word
if2id_valid  output  1  IF/ID holds a valid instruction
if2id_pc  output  32  PC of if2id_instruction
if2id_instruction  output  32  fetched instruction

Behaviour:
- Reset (rst=0, async):
  - State S_RST; fetch_pc=RESET_VECTOR; drop=0; buf_valid=0.
  - Outputs: if2id_valid=0, if2id_pc=0, if2id_instruction=0, ibus_read=0, ibus_addr=RESET_VECTOR.
- State machine (3 states):
  - S_RST: one idle cycle after reset release -> S_REQ.
  - S_REQ:
    - ibus_read = can_issue; ibus_addr = fetch_pc.
    - If accepted (read & ready): fetch_pc += 4, -> S_WAIT.
  - S_WAIT:
    - Wait for ibus_rvalid.
    - On rvalid, ibus_read = can_issue in the same cycle, giving back-to-back issue.
    - Accepted -> stay S_WAIT, fetch_pc += 4; not accepted -> S_REQ.
- can_issue = ~buf_valid & ~(if_stall & if2id_valid & rvalid_kept).
  - rvalid_kept = ibus_rvalid & ~drop & ~redirect_valid.
- Throughput: 1 instr/cycle with a zero-wait bus. Fetch-to-if2id latency: response cycle +1.
- IF/ID update, priority high to low:
  1. redirect_valid: if2id_valid<=0, buf_valid<=0.
  2. if_stall & if2id_valid: hold if2id; a kept response is written to the buffer (buf_valid<=1, buf_pc, buf_instr).
  3. buf_valid: if2id<=buffer, buf_valid<=0; a simultaneous kept response cannot occur (can_issue blocked).
  4. rvalid_kept: if2id<={1, req_pc, ibus_rdata}.
  5. Otherwise: if2id_valid<=0.
- A stall with if2id_valid=0 does not hold; a bubble may be filled.
- req_pc is latched at accept; at most one outstanding request, so a single register suffices.
- Redirect:
  - fetch_pc <= {redirect_pc[31:2],2'b00}, overriding any +4 in the same cycle.
  - In-flight request (S_WAIT, no rvalid this cycle): drop<=1.
  - Any request accepted in the redirect cycle: drop<=1.
  - A response with drop=1 is discarded and clears drop.
  - Redirect + stall in the same cycle: redirect wins.
- ibus_rvalid in S_RST or S_REQ is a protocol error and is ignored.
- Address wrap: fetch_pc + 4 wraps modulo 2^32 (0xFFFF_FFFC -> 0).
- ibus_read/ibus_addr are stable while ibus_read=1 and ibus_ready=0, unless a redirect occurs; then the address may change.

Test Plan:
- Reset release, ready=1, rvalid the cycle after accept, rdata=addr^0xA5:
  - addrs 0,4,8,C issued back-to-back.
  - if2id_valid=1 from cycle 3 with pc 0,4,8 each cycle.
  - if2id_valid=0 during reset and S_RST.
- Stall for 3 cycles while pc=4 is in IF/ID and the pc=8 response arrives:
  - if2id holds pc=4; the buffer captures pc=8; ibus_read=0.
  - After stall release: pc=8 then pc=C, nothing lost or duplicated.
- Redirect to 0x100 while pc=0x10 is in flight (rvalid 2 cycles later):
  - The pc=0x10 response is discarded.
  - Next ibus_addr=0x100; if2id shows 0x100 with no stale valid in between.
- Redirect to 0x203 in the same cycle the bus accepts pc=0x20:
  - The 0x20 response is dropped.
  - The following request address is 0x200.
- ready held low 5 cycles:
  - ibus_addr stable; if2id_valid=0.
  - Async reset asserted mid-wait: all outputs return to reset values immediately; fetch restarts at RESET_VECTOR.
- Start from RESET_VECTOR=32'hFFFF_FFF8: fetches FFF8, FFFC, then 0x0 (wrap).

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch : IF stage of the veriRISCV 5-stage core.
//
// Owns the fetch PC, issues word fetches on a req/ready/rvalid instruction bus
// (at most one request outstanding), and drives the IF/ID pipeline register.
// A one-entry skid buffer absorbs a response that lands while ID is stalled,
// and a drop flag discards the response of a request made stale by a redirect.
//
// Ports:
//   clk                core clock
//   rst                asynchronous active-low reset
//   if_stall           hold IF/ID (load-use hazard from the HDU)
//   redirect_valid     taken branch/jump: flush IF and refetch from redirect_pc
//   redirect_pc        redirect target, bits [1:0] forced to zero
//   ibus_read          fetch request
//   ibus_addr          word-aligned fetch address
//   ibus_ready         request accepted this cycle when ibus_read=1
//   ibus_rvalid        response valid, one per accepted request
//   ibus_rdata         instruction word of the response
//   if2id_valid        IF/ID holds a valid instruction
//   if2id_pc           PC of if2id_instruction
//   if2id_instruction  fetched instruction word
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ibus_read,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ready,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
   output logic        if2id_valid,
   output logic [31:0] if2id_pc,
   output logic [31:0] if2id_instruction
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_req_pc;
   logic        r_drop;
   logic        r_buf_valid;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_instr;

   logic        w_in_wait;
   logic        w_rvalid_kept;
   logic        w_can_issue;
   logic        w_read;
   logic        w_accept;
   logic [31:0] w_redirect_pc;

   // Request qualification: which response is kept and whether a new fetch may go out
   always_comb begin
      w_in_wait     = (r_state == S_WAIT);
      // rvalid outside S_WAIT is a bus protocol error and never reaches IF/ID
      w_rvalid_kept = w_in_wait & ibus_rvalid & ~r_drop & ~redirect_valid;
      // A kept response that must go to the buffer leaves no room for another
      w_can_issue   = ~r_buf_valid & ~(if_stall & if2id_valid & w_rvalid_kept);
      w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
      case (r_state)
         S_REQ:   w_read = w_can_issue;
         S_WAIT:  w_read = ibus_rvalid & w_can_issue;
         default: w_read = 1'b0;
      endcase
      w_accept = w_read & ibus_ready;
   end

   assign ibus_read = w_read;
   assign ibus_addr = r_fetch_pc;

   // Fetch FSM: state, fetch PC, PC of the outstanding request and drop flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_RST;
         r_fetch_pc <= RESET_VECTOR;
         r_req_pc   <= 32'h0000_0000;
         r_drop     <= 1'b0;
      end else begin
         case (r_state)
            S_RST: begin
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (w_accept) r_state <= S_WAIT;
               else          r_state <= S_REQ;
            end
            S_WAIT: begin
               if (ibus_rvalid) r_state <= w_accept ? S_WAIT : S_REQ;
               else             r_state <= S_WAIT;
            end
            default: begin
               r_state <= S_RST;
            end
         endcase

         // Redirect target overrides the sequential increment
         if (redirect_valid)  r_fetch_pc <= w_redirect_pc;
         else if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
         else                 r_fetch_pc <= r_fetch_pc;

         // Only one request in flight, so one PC register tags its response
         if (w_accept) r_req_pc <= r_fetch_pc;
         else          r_req_pc <= r_req_pc;

         // Mark stale: a request still in flight, or one accepted under redirect
         if (redirect_valid & ((w_in_wait & ~ibus_rvalid) | w_accept))
            r_drop <= 1'b1;
         else if (w_in_wait & ibus_rvalid)
            r_drop <= 1'b0;
         else
            r_drop <= r_drop;
      end
   end

   // IF/ID register and skid buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if2id_valid       <= 1'b0;
         if2id_pc          <= 32'h0000_0000;
         if2id_instruction <= 32'h0000_0000;
         r_buf_valid       <= 1'b0;
         r_buf_pc          <= 32'h0000_0000;
         r_buf_instr       <= 32'h0000_0000;
      end else begin
         if (redirect_valid) begin
            if2id_valid <= 1'b0;
            r_buf_valid <= 1'b0;
         end else if (if_stall & if2id_valid) begin
            // ID is holding: park an arriving instruction in the buffer
            if (w_rvalid_kept) begin
               r_buf_valid <= 1'b1;
               r_buf_pc    <= r_req_pc;
               r_buf_instr <= ibus_rdata;
            end else begin
               r_buf_valid <= r_buf_valid;
            end
         end else if (r_buf_valid) begin
            if2id_valid       <= 1'b1;
            if2id_pc          <= r_buf_pc;
            if2id_instruction <= r_buf_instr;
            r_buf_valid       <= 1'b0;
         end else if (w_rvalid_kept) begin
            if2id_valid       <= 1'b1;
            if2id_pc          <= r_req_pc;
            if2id_instruction <= ibus_rdata;
         end else begin
            if2id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch : self-checking bench for instr_fetch.
// A bus model answers each accepted fetch with rdata = addr ^ 0xA5 after a
// programmable latency. Responses that no redirect has made stale are pushed
// to a scoreboard queue; each instruction ID consumes from IF/ID is popped and
// compared. Scenario tasks add inline cycle-exact checks.
// A second instance with RESET_VECTOR=0xFFFF_FFF8 covers address wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        ibus_read, ibus_ready, ibus_rvalid;
   logic [31:0] ibus_addr, ibus_rdata;
   logic        if2id_valid;
   logic [31:0] if2id_pc, if2id_instruction;

   logic        rst_w, rd_w, rvalid_w, valid_w;
   logic [31:0] addr_w, rdata_w, pc_w, instr_w;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] sb_q[$];
   logic        pend_valid;
   logic [31:0] pend_addr;
   int          pend_epoch, pend_cnt, epoch, bus_lat;

   logic        acc_w;
   logic [31:0] acc_addr_w;

   instr_fetch #(.RESET_VECTOR(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .if_stall(if_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ibus_read(ibus_read), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .if2id_valid(if2id_valid), .if2id_pc(if2id_pc),
      .if2id_instruction(if2id_instruction)
   );

   instr_fetch #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .rst(rst_w), .if_stall(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
      .ibus_read(rd_w), .ibus_addr(addr_w), .ibus_ready(1'b1),
      .ibus_rvalid(rvalid_w), .ibus_rdata(rdata_w),
      .if2id_valid(valid_w), .if2id_pc(pc_w),
      .if2id_instruction(instr_w)
   );

   // Main bus model + scoreboard: drive at negedge, sample 1 time unit later
   always @(negedge clk) begin
      logic [31:0] exp_pc;
      if (pend_valid && pend_cnt == 0) begin
         ibus_rvalid = 1'b1;
         ibus_rdata  = pend_addr ^ 32'h0000_00A5;
      end else begin
         ibus_rvalid = 1'b0;
         ibus_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      if (rst) begin
         if (ibus_rvalid) begin
            if (pend_epoch == epoch && !redirect_valid) sb_q.push_back(pend_addr);
            pend_valid = 1'b0;
         end else if (pend_valid) begin
            pend_cnt = pend_cnt - 1;
         end
         if (ibus_read && ibus_ready) begin
            n_cmp++;
            if (pend_valid) begin
               n_err++;
               $display("FAIL bus_one_outstanding: accept of %h while %h still pending", ibus_addr, pend_addr);
            end
            pend_valid = 1'b1;
            pend_addr  = ibus_addr;
            pend_epoch = epoch;
            pend_cnt   = bus_lat - 1;
         end
         if (redirect_valid) epoch++;
         if (if2id_valid && (!if_stall || redirect_valid)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: got pc %h instr %h, expected no instruction", if2id_pc, if2id_instruction);
            end else begin
               exp_pc = sb_q.pop_front();
               if (if2id_pc !== exp_pc || if2id_instruction !== (exp_pc ^ 32'h0000_00A5)) begin
                  n_err++;
                  $display("FAIL sb_if2id: got pc %h instr %h, expected pc %h instr %h",
                           if2id_pc, if2id_instruction, exp_pc, exp_pc ^ 32'h0000_00A5);
               end
            end
         end
      end
   end

   // Zero-wait bus for the wrap instance: respond the cycle after accept
   always @(negedge clk) begin
      rvalid_w = acc_w;
      rdata_w  = acc_addr_w ^ 32'h0000_00A5;
      #1;
      acc_w      = rst_w & rd_w;
      acc_addr_w = addr_w;
   end

   task automatic flush_model();
      sb_q.delete();
      pend_valid  = 1'b0;
      ibus_rvalid = 1'b0;
      epoch++;
   endtask

   task automatic test_reset();
      logic [31:0] ea[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      logic        ev[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] ep[5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (ibus_read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b expected 0", ibus_read); end
      n_cmp++; if (ibus_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", ibus_addr); end
      n_cmp++; if (if2id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", if2id_valid); end
      n_cmp++; if (if2id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", if2id_pc); end
      n_cmp++; if (if2id_instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", if2id_instruction); end
      @(negedge clk);
      rst = 1'b1;
      #2;
      n_cmp++; if (ibus_read !== 1'b0 || if2id_valid !== 1'b0) begin
         n_err++; $display("FAIL s_rst_idle: got read %b valid %b expected 0 0", ibus_read, if2id_valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         n_cmp++;
         if (ibus_read !== 1'b1 || ibus_addr !== ea[i] || if2id_valid !== ev[i] || if2id_pc !== ep[i]) begin
            n_err++;
            $display("FAIL startup_c%0d: got read %b addr %h valid %b pc %h expected 1 %h %b %h",
                     i + 1, ibus_read, ibus_addr, if2id_valid, if2id_pc, ea[i], ev[i], ep[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      @(negedge clk);
      if_stall = 1'b1;
      #2;
      held = if2id_pc;
      n_cmp++; if (if2id_valid !== 1'b1 || ibus_read !== 1'b0) begin
         n_err++; $display("FAIL stall_start: got valid %b read %b expected 1 0", if2id_valid, ibus_read);
      end
      repeat (2) begin
         @(negedge clk);
         #2;
         n_cmp++; if (if2id_pc !== held || ibus_read !== 1'b0) begin
            n_err++; $display("FAIL stall_hold: got pc %h read %b expected %h 0", if2id_pc, ibus_read, held);
         end
      end
      @(negedge clk);
      if_stall = 1'b0;
      #2;
      n_cmp++; if (if2id_pc !== held || ibus_read !== 1'b0) begin
         n_err++; $display("FAIL stall_release: got pc %h read %b expected %h 0", if2id_pc, ibus_read, held);
      end
      @(negedge clk);
      #2;
      n_cmp++; if (if2id_valid !== 1'b1 || if2id_pc !== held + 32'd4) begin
         n_err++; $display("FAIL stall_buffer_out: got valid %b pc %h expected 1 %h", if2id_valid, if2id_pc, held + 32'd4);
      end
   endtask

   task automatic wait_read(input string name);
      bit got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #2;
         if (ibus_read) begin got = 1'b1; break; end
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL %s_timeout: got no ibus_read, expected one", name); end
   endtask

   task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
      bit got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #2;
         if (if2id_valid) begin got = 1'b1; break; end
      end
      n_cmp++; if (!got || if2id_pc !== exp_pc) begin
         n_err++; $display("FAIL %s_first_pc: got valid %b pc %h expected 1 %h", name, got, if2id_pc, exp_pc);
      end
   endtask

   task automatic test_redirect_inflight();
      bus_lat = 2;
      wait_read("redir_inflight");
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      #2;
      n_cmp++; if (ibus_read !== 1'b0) begin n_err++; $display("FAIL redir_inflight_read: got %b expected 0", ibus_read); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (ibus_read !== 1'b1 || ibus_addr !== 32'h0000_0100) begin
         n_err++; $display("FAIL redir_inflight_addr: got read %b addr %h expected 1 00000100", ibus_read, ibus_addr);
      end
      wait_first_valid("redir_inflight", 32'h0000_0100);
   endtask

   task automatic test_redirect_accept();
      bus_lat = 1;
      wait_read("redir_accept");
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      #2;
      n_cmp++; if (ibus_read !== 1'b1) begin n_err++; $display("FAIL redir_accept_read: got %b expected 1", ibus_read); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (ibus_read !== 1'b1 || ibus_addr !== 32'h0000_0200) begin
         n_err++; $display("FAIL redir_accept_addr: got read %b addr %h expected 1 00000200", ibus_read, ibus_addr);
      end
      wait_first_valid("redir_accept", 32'h0000_0200);
   endtask

   task automatic test_ready_low_reset();
      logic [31:0] a0;
      @(negedge clk);
      ibus_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         if (i == 0) a0 = ibus_addr;
         n_cmp++; if (ibus_read !== 1'b1 || ibus_addr !== a0) begin
            n_err++; $display("FAIL ready_low_hold_c%0d: got read %b addr %h expected 1 %h", i, ibus_read, ibus_addr, a0);
         end
         if (i > 0) begin
            n_cmp++; if (if2id_valid !== 1'b0) begin
               n_err++; $display("FAIL ready_low_valid_c%0d: got %b expected 0", i, if2id_valid);
            end
         end
      end
      @(negedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_cmp++; if (ibus_read !== 1'b0 || ibus_addr !== 32'h0 || if2id_valid !== 1'b0 ||
                   if2id_pc !== 32'h0 || if2id_instruction !== 32'h0) begin
         n_err++; $display("FAIL async_rst: got read %b addr %h valid %b pc %h instr %h expected all 0",
                           ibus_read, ibus_addr, if2id_valid, if2id_pc, if2id_instruction);
      end
      flush_model();
      repeat (2) @(negedge clk);
      rst        = 1'b1;
      ibus_ready = 1'b1;
      #2;
      wait_read("restart");
      n_cmp++; if (ibus_addr !== 32'h0) begin n_err++; $display("FAIL restart_addr: got %h expected 0", ibus_addr); end
   endtask

   task automatic test_wrap();
      logic [31:0] wq[$] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      logic [31:0] e;
      @(negedge clk);
      rst_w = 1'b1;
      for (int k = 0; k < 20 && wq.size() > 0; k++) begin
         @(negedge clk);
         #2;
         if (rd_w) begin
            e = wq.pop_front();
            n_cmp++; if (addr_w !== e) begin n_err++; $display("FAIL wrap_addr: got %h expected %h", addr_w, e); end
         end
      end
      n_cmp++; if (wq.size() != 0) begin n_err++; $display("FAIL wrap_timeout: got %0d fetches missing, expected 0", wq.size()); end
   endtask

   task automatic test_drain();
      @(negedge clk);
      ibus_ready = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      n_cmp++; if (sb_q.size() != 0) begin
         n_err++; $display("FAIL drain: got %0d undelivered instructions, expected 0", sb_q.size());
      end
   endtask

   initial begin
      rst = 1'b0; rst_w = 1'b0;
      if_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      ibus_ready = 1'b1; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
      pend_valid = 1'b0; pend_addr = 32'h0; pend_epoch = 0; pend_cnt = 0;
      epoch = 0; bus_lat = 1;
      acc_w = 1'b0; acc_addr_w = 32'h0; rvalid_w = 1'b0; rdata_w = 32'h0;
      test_reset();
      test_stall();
      test_redirect_inflight();
      test_redirect_accept();
      test_ready_low_reset();
      test_wrap();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
